// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter with bounded lock bursts in front of a
// flop-based register bank; combinational read port.
module reg_bank_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int MAX_BURST = 4,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] wr_addr,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [IDW-1:0]          gnt_id,
  output logic                    busy,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]       rd_data
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [IDW-1:0]      gnt_id_q, gnt_id_d;
  logic                busy_q, busy_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   bank_q [DEPTH];
  logic [DATA_W-1:0]   bank_d [DEPTH];

  logic [N_REQ-1:0]    cand;
  logic                hold;
  logic                found;
  logic [IDW-1:0]      win;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [IW-1:0]       widx;
  logic [IW-1:0]       ridx;

  // Hold only while the grantee keeps both req and lock asserted
  assign hold = (state_q == GRANT) &&
                req[gnt_id_q] && lock[gnt_id_q] &&
                (cnt_q < CNT_LAST);

  assign cand = req & ~gnt_q;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = GRANT;
          gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          gnt_id_d = win;
          ptr_d    = (int'(win) == N_REQ-1) ? '0 : win + 1'b1;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        if (hold) begin
          cnt_d = cnt_q + 1'b1;
        end else if (found) begin
          gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          gnt_id_d = win;
          ptr_d    = (int'(win) == N_REQ-1) ? '0 : win + 1'b1;
          cnt_d    = '0;
        end else begin
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        cnt_d    = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  // Write port follows the registered grant with that cycle's live inputs
  assign waddr = wr_addr[gnt_id_q*ADDR_W +: ADDR_W];
  assign wdata = wr_data[gnt_id_q*DATA_W +: DATA_W];
  assign widx  = IW'(waddr);

  always_comb begin
    bank_d = bank_q;
    if (state_q == GRANT && (32'(waddr) < DEPTH)) begin
      bank_d[widx] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign ridx    = IW'(rd_addr);
  assign rd_data = (32'(rd_addr) < DEPTH) ? bank_q[ridx] : '0;

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule
